// File: rtl/fft_peak_finder.sv
// Sweeps the FFT result memory once per start and reports the bin with the largest re^2+im^2.
// Latency: done is high in cycle N_POINTS+RD_LATENCY+3 after the start edge; results are valid in that cycle.
// Backpressure: none; start is ignored while busy and the memory is read one address per cycle.
module fft_peak_finder #(
  parameter int N_POINTS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 1,
  parameter int SKIP_DC    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_mem_address,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_peak_index,
  output logic [DATA_W-1:0] o_peak_power
);

  localparam int                HALF       = DATA_W / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_POINTS - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LATENCY + 1);
  // With DC excluded, an all-zero spectrum must report bin 1, so the cleared best starts there.
  localparam logic [ADDR_W-1:0] CLR_IDX    = (SKIP_DC != 0) ? ADDR_W'(1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_issue;
  logic              w_drain_end;
  logic [ADDR_W-1:0] r_cnt;
  logic [2:0]        r_drain;

  // Read-tag pipeline: valid/index follow each address until its data appears on i_mem_data.
  logic              r_rd_vld [RD_LATENCY];
  logic [ADDR_W-1:0] r_rd_idx [RD_LATENCY];
  logic              w_issue_vld;

  logic              r_cap_vld;
  logic [ADDR_W-1:0] r_cap_idx;
  logic [DATA_W-1:0] r_cap_dat;

  logic signed [HALF-1:0]   w_re;
  logic signed [HALF-1:0]   w_im;
  logic signed [DATA_W-1:0] w_re_sq;
  logic signed [DATA_W-1:0] w_im_sq;

  logic              r_sq_vld;
  logic [ADDR_W-1:0] r_sq_idx;
  logic [DATA_W-1:0] r_sq_re;
  logic [DATA_W-1:0] r_sq_im;

  logic [DATA_W-1:0] w_sum;
  logic              w_better;
  logic [DATA_W-1:0] w_best_pow_nxt;
  logic [ADDR_W-1:0] w_best_idx_nxt;
  logic [DATA_W-1:0] r_best_pow;
  logic [ADDR_W-1:0] r_best_idx;
  logic [DATA_W-1:0] r_peak_pow;
  logic [ADDR_W-1:0] r_peak_idx;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_drain_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_issue = 1'b1;
        if (r_cnt == LAST_ADDR) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_drain_end = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_mem_address = (r_state == S_READ) ? r_cnt : '0;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_peak_index  = r_peak_idx;
  assign o_peak_power  = r_peak_pow;

  // Address counter for the sweep and cycle counter for the drain wait.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_drain <= '0;
    end else begin
      if (w_accept)     r_cnt <= '0;
      else if (w_issue) r_cnt <= (r_cnt == LAST_ADDR) ? '0 : r_cnt + 1'b1;
      if (r_state != S_DRAIN) r_drain <= '0;
      else                    r_drain <= r_drain + 3'd1;
    end
  end

  // Bin 0 is still read when DC is skipped; only its valid bit is dropped.
  assign w_issue_vld = w_issue && !((SKIP_DC != 0) && (r_cnt == '0));

  // Delay the read tag by the memory latency so it lines up with i_mem_data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_rd_vld[i] <= 1'b0;
        r_rd_idx[i] <= '0;
      end
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_idx[i] <= r_rd_idx[i-1];
      end
      r_rd_vld[0] <= w_issue_vld;
      r_rd_idx[0] <= r_cnt;
    end
  end

  // Capture stage: register the memory word so no path runs from i_mem_data to the multipliers' outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_cap_dat <= '0;
    end else begin
      r_cap_vld <= r_rd_vld[RD_LATENCY-1];
      r_cap_idx <= r_rd_idx[RD_LATENCY-1];
      r_cap_dat <= i_mem_data;
    end
  end

  // Signed halves squared into full-width products; a square of a signed value is never negative.
  assign w_re    = r_cap_dat[DATA_W-1:HALF];
  assign w_im    = r_cap_dat[HALF-1:0];
  assign w_re_sq = w_re * w_re;
  assign w_im_sq = w_im * w_im;

  // Square stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sq_vld <= 1'b0;
      r_sq_idx <= '0;
      r_sq_re  <= '0;
      r_sq_im  <= '0;
    end else begin
      r_sq_vld <= r_cap_vld;
      r_sq_idx <= r_cap_idx;
      r_sq_re  <= w_re_sq;
      r_sq_im  <= w_im_sq;
    end
  end

  // Sum and compare share a cycle so the last bin's result is ready on the edge that enters DONE.
  // Strictly-greater keeps the lowest index on ties. Max sum is 2^63, so DATA_W bits never overflow.
  assign w_sum          = r_sq_re + r_sq_im;
  assign w_better       = r_sq_vld && (w_sum > r_best_pow);
  assign w_best_pow_nxt = w_better ? w_sum    : r_best_pow;
  assign w_best_idx_nxt = w_better ? r_sq_idx : r_best_idx;

  // Running best, cleared when a sweep is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best_pow <= '0;
      r_best_idx <= '0;
    end else if (w_accept) begin
      r_best_pow <= '0;
      r_best_idx <= CLR_IDX;
    end else begin
      r_best_pow <= w_best_pow_nxt;
      r_best_idx <= w_best_idx_nxt;
    end
  end

  // Published result: loaded on entry to DONE and held until the next sweep completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_peak_pow <= '0;
      r_peak_idx <= '0;
    end else if (w_drain_end) begin
      r_peak_pow <= w_best_pow_nxt;
      r_peak_idx <= w_best_idx_nxt;
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Bench: four peak finders (latency 1/2/3, and latency 1 with DC skipped) share one memory image and start.
module tb_fft_peak_finder;

  logic clk;
  logic rst_n;
  logic start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem [32];

  logic [4:0]  addr_w [4];
  logic [63:0] rdat   [4];
  logic        busy_w [4];
  logic        done_w [4];
  logic [4:0]  idx_w  [4];
  logic [63:0] pow_w  [4];

  int lat [4] = '{1, 2, 3, 1};
  bit skp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Memory models with 1, 2 and 3 cycles of read latency.
  logic [63:0] p2, p3a, p3b;
  always @(posedge clk) begin
    rdat[0] <= mem[addr_w[0]];
    p2      <= mem[addr_w[1]];
    rdat[1] <= p2;
    p3a     <= mem[addr_w[2]];
    p3b     <= p3a;
    rdat[2] <= p3b;
    rdat[3] <= mem[addr_w[3]];
  end

  fft_peak_finder #(.RD_LATENCY(1), .SKIP_DC(0)) u_l1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_mem_address(addr_w[0]),
    .i_mem_data(rdat[0]), .o_busy(busy_w[0]), .o_done(done_w[0]),
    .o_peak_index(idx_w[0]), .o_peak_power(pow_w[0]));
  fft_peak_finder #(.RD_LATENCY(2), .SKIP_DC(0)) u_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_mem_address(addr_w[1]),
    .i_mem_data(rdat[1]), .o_busy(busy_w[1]), .o_done(done_w[1]),
    .o_peak_index(idx_w[1]), .o_peak_power(pow_w[1]));
  fft_peak_finder #(.RD_LATENCY(3), .SKIP_DC(0)) u_l3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_mem_address(addr_w[2]),
    .i_mem_data(rdat[2]), .o_busy(busy_w[2]), .o_done(done_w[2]),
    .o_peak_index(idx_w[2]), .o_peak_power(pow_w[2]));
  fft_peak_finder #(.RD_LATENCY(1), .SKIP_DC(1)) u_dc (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_mem_address(addr_w[3]),
    .i_mem_data(rdat[3]), .o_busy(busy_w[3]), .o_done(done_w[3]),
    .o_peak_index(idx_w[3]), .o_peak_power(pow_w[3]));

  typedef struct {
    string       name;
    int          bg;      // 0: zero background, 1: small random background
    int          bin_a;   // -1: unused
    logic [63:0] dat_a;
    int          bin_b;
    logic [63:0] dat_b;
    logic [4:0]  idx0;    // expected with DC included
    logic [63:0] pow0;
    logic [4:0]  idx1;    // expected with DC skipped
    logic [63:0] pow1;
  } vec_t;

  vec_t vt [5];

  int          n_vec;
  int          n_err;
  logic [4:0]  prev_idx;
  logic [63:0] prev_pow;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_vec(input int v);
    int re;
    int im;
    for (int k = 0; k < 32; k++) begin
      if (vt[v].bg == 1) begin
        re = int'($urandom_range(0, 200)) - 100;
        im = int'($urandom_range(0, 200)) - 100;
        mem[k] = {re, im};
      end else begin
        mem[k] = 64'd0;
      end
    end
    if (vt[v].bin_a >= 0) mem[vt[v].bin_a] = vt[v].dat_a;
    if (vt[v].bin_b >= 0) mem[vt[v].bin_b] = vt[v].dat_b;
  endtask

  task automatic load_rand();
    for (int k = 0; k < 32; k++) mem[k] = {$urandom, $urandom};
  endtask

  // Reference: plain search over the memory image, lowest index wins ties.
  task automatic model(input bit skip, output logic [4:0] bi, output logic [63:0] bp);
    longint      re;
    longint      im;
    logic [63:0] p;
    bi = skip ? 5'd1 : 5'd0;
    bp = 64'd0;
    for (int k = (skip ? 1 : 0); k < 32; k++) begin
      re = longint'($signed(mem[k][63:32]));
      im = longint'($signed(mem[k][31:0]));
      p  = re * re + im * im;
      if (p > bp) begin
        bp = p;
        bi = 5'(k);
      end
    end
  endtask

  task automatic run_sweep(input string tag, input int retrig,
                           input logic [4:0] ei0, input logic [63:0] ep0,
                           input logic [4:0] ei1, input logic [63:0] ep1);
    int          dcyc [4];
    int          dcnt [4];
    logic [4:0]  gi   [4];
    logic [63:0] gp   [4];
    for (int i = 0; i < 4; i++) begin
      dcyc[i] = -1; dcnt[i] = 0; gi[i] = '0; gp[i] = '0;
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (done_w[i]) begin
          dcnt[i]++;
          if (dcyc[i] < 0) begin
            dcyc[i] = c; gi[i] = idx_w[i]; gp[i] = pow_w[i];
          end
        end
      end
      if (c == 1) begin
        chk({tag, " addr@1"}, 64'(addr_w[0]), 64'd0);
        chk({tag, " busy@1"}, 64'(busy_w[0]), 64'd1);
      end
      if (c == 8)  chk({tag, " addr@8"}, 64'(addr_w[0]), 64'd7);
      if (c == 20) begin
        chk({tag, " hold idx"}, 64'(idx_w[0]), 64'(prev_idx));
        chk({tag, " hold pow"}, pow_w[0], prev_pow);
      end
      if (c == 37) chk({tag, " busy@37"}, 64'(busy_w[0]), 64'd0);
      start = (retrig > 0) && (c == retrig);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s u%0d done cycle", tag, i), 64'(dcyc[i]), 64'(35 + lat[i]));
      chk($sformatf("%s u%0d done count", tag, i), 64'(dcnt[i]), 64'd1);
      chk($sformatf("%s u%0d index", tag, i), 64'(gi[i]), 64'(skp[i] ? ei1 : ei0));
      chk($sformatf("%s u%0d power", tag, i), gp[i], skp[i] ? ep1 : ep0);
    end
    prev_idx = ei0;
    prev_pow = ep0;
  endtask

  initial begin
    logic [4:0]  mi0, mi1;
    logic [63:0] mp0, mp1;
    int          hc [$];

    n_vec = 0;
    n_err = 0;
    prev_idx = '0;
    prev_pow = '0;
    start = 1'b0;
    rst_n = 1'b1;

    vt[0] = '{"tone",    0, 7,  {32'd3, 32'hFFFF_FFFC}, -1, 64'd0,
              5'd7, 64'd25, 5'd7, 64'd25};
    vt[1] = '{"extreme", 1, 5,  64'h8000_0000_8000_0000, 20, 64'h8000_0000_8000_0000,
              5'd5, 64'h8000_0000_0000_0000, 5'd5, 64'h8000_0000_0000_0000};
    vt[2] = '{"dc",      0, 0,  {32'd1000, 32'd0}, 9, {32'd10, 32'd10},
              5'd0, 64'd1000000, 5'd9, 64'd200};
    vt[3] = '{"zero",    0, -1, 64'd0, -1, 64'd0,
              5'd0, 64'd0, 5'd1, 64'd0};
    vt[4] = '{"lastbin", 0, 31, {32'd0, 32'hFFFF_FFF9}, 2, {32'd5, 32'd4},
              5'd31, 64'd49, 5'd31, 64'd49};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset addr", 64'(addr_w[0]), 64'd0);
    chk("reset busy", 64'(busy_w[0]), 64'd0);
    chk("reset done", 64'(done_w[0]), 64'd0);
    chk("reset idx",  64'(idx_w[0]),  64'd0);
    chk("reset pow",  pow_w[0],       64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_sweep(vt[v].name, 0, vt[v].idx0, vt[v].pow0, vt[v].idx1, vt[v].pow1);
    end

    // A second start at cycle 10 must be ignored.
    load_vec(0);
    run_sweep("retrig", 10, vt[0].idx0, vt[0].pow0, vt[0].idx1, vt[0].pow1);

    // Random spectra against the reference search.
    for (int r = 0; r < 2; r++) begin
      load_rand();
      model(1'b0, mi0, mp0);
      model(1'b1, mi1, mp1);
      run_sweep($sformatf("rand%0d", r), 0, mi0, mp0, mi1, mp1);
    end

    // Start held high: back-to-back sweeps every 37 cycles.
    load_vec(2);
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 112; c++) begin
      @(negedge clk);
      if (done_w[0]) hc.push_back(c);
      if (c == 110) start = 1'b0;
    end
    repeat (50) @(negedge clk);
    chk("held done count", 64'(hc.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("held done %0d cycle", k), 64'((hc.size() > k) ? hc[k] : -1), 64'(36 + 37 * k));
    chk("held idx", 64'(idx_w[0]), 64'(vt[2].idx0));
    chk("held pow", pow_w[0], vt[2].pow0);

    // Reset in the middle of a sweep.
    load_vec(4);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst addr", 64'(addr_w[0]), 64'd0);
    chk("midrst busy", 64'(busy_w[0]), 64'd0);
    chk("midrst done", 64'(done_w[0]), 64'd0);
    chk("midrst idx",  64'(idx_w[3]),  64'd0);
    chk("midrst pow",  pow_w[0],       64'd0);
    chk("midrst busy3", 64'(busy_w[2]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    prev_idx = '0;
    prev_pow = '0;
    load_vec(0);
    run_sweep("postrst", 0, vt[0].idx0, vt[0].pow0, vt[0].idx1, vt[0].pow1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_finder.md
# fft_peak_finder

Post-FFT spectral peak detector for the radix-2 FFT system. After the FFT core signals completion, the block sweeps the 32-word FFT result memory over the shared read port, computes |X[k]|² = re² + im² for every bin, and reports the index and power of the strongest bin. It sits directly downstream of the FFT core and time-shares the FFT memory address bus with the result checker.

## Interface
- N_POINTS, 32: number of FFT bins swept (power of two)
- ADDR_W, 5: memory address width, log2(N_POINTS)
- DATA_W, 64: memory word width; [DATA_W-1:DATA_W/2] = real, [DATA_W/2-1:0] = imag, both two's complement
- RD_LATENCY, 1: read latency of the result memory in clock cycles (1..3)
- SKIP_DC, 0: when 1, bin 0 is excluded from the search

- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a sweep; sampled on rising edge while idle
- mem_address  out  ADDR_W  read address to FFT result memory
- mem_data  in  DATA_W  read data, valid RD_LATENCY cycles after address
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when results are updated
- peak_index  out  ADDR_W  bin index of maximum power
- peak_power  out  DATA_W  maximum re² + im², unsigned

## Operation
- Reset: state IDLE; mem_address, busy, done, peak_index, peak_power all 0.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: mem_address = 0. start=1 -> READ; address counter cleared.
  - READ: mem_address = counter, incremented every cycle; after address N_POINTS-1 is driven -> DRAIN. Counter does not wrap into a second sweep.
  - DRAIN: waits RD_LATENCY+2 cycles for the pipeline to empty -> DONE.
  - DONE: done=1 for one cycle, peak_index/peak_power loaded from running best -> IDLE.
- Datapath pipeline (valid bit and index travel alongside data): capture mem_data -> stage 1 square both halves (each product 2·(DATA_W/2) bits, unsigned) -> stage 2 sum, truncated to DATA_W bits (maximum (-2^31)² + (-2^31)² = 2^63 fits in 64 bits unsigned, no overflow) -> stage 3 compare with running best.
- Running best cleared to power 0, index 0 at sweep start. Update only on strictly greater power, so the lowest index wins ties; an all-zero spectrum reports index 0 (index 1 when SKIP_DC=1), power 0.
- SKIP_DC=1: bin 0 is still read but its valid bit is suppressed.
- start while busy is ignored; start held high in IDLE after DONE begins a new sweep immediately.
- peak_index/peak_power hold the last completed result between sweeps and change only in DONE.
- rst_n low mid-sweep aborts immediately; all outputs return to reset values, with no done pulse.

## Timing
- start sampled at edge E0; mem_address = 0 during the cycle after E0, address k during cycle k+1.
- busy rises after E0 and falls on the edge that ends DONE.
- done is high during cycle N_POINTS + RD_LATENCY + 3 after E0 (36 with defaults); the outputs are valid in that same cycle.
- Minimum spacing between start acceptances: N_POINTS + RD_LATENCY + 4 cycles.
- No combinational path from mem_data to any output.

## Test plan
- Single tone: memory holds 0 everywhere except bin 7 = (re 3, im -4) -> done at cycle 36, peak_index 7, peak_power 25.
- Tie and extremes: bins 5 and 20 = (re -2^31, im -2^31), the rest random small values -> peak_index 5, peak_power 2^63 (0x8000_0000_0000_0000).
- DC handling: bin 0 = (1000, 0), bin 9 = (10, 10). With SKIP_DC=0 -> index 0, power 1000000. With SKIP_DC=1 -> index 9, power 200.
- Retrigger and protection: pulse start again at cycle 10 of a sweep -> ignored, exactly one done pulse. Hold start high -> back-to-back sweeps with done every 37 cycles.
- Reset mid-sweep: rst_n low at cycle 15 -> busy, done, mem_address, peak_index, peak_power are 0 asynchronously. A fresh start then yields a correct result.
- Latency sweep: RD_LATENCY = 1, 2, 3 with a random spectrum -> result matches the reference model and done arrives at cycle 35 + RD_LATENCY.
